hq2x_vga_out: RTL
=================

Name: hq2x_vga_out

Overview:
- Downstream stage of the Hq2x scaler.
- Generates a 512x480 VGA raster from the scaler's output line buffer. It drives the scaler's read_x, reset_line and reset_frame. It delays outpixel into aligned rgb/de/hsync/vsync.
- Each 256-pixel input line becomes two 512-pixel output lines. read_x[9] selects the upper or lower line of the pair, and read_x[8:0] is the output x.
- Sits between Hq2x and the board DAC / OSD mixer.

Parameters:
H_ACTIVE, 512, visible pixels per line
H_FP, 16, front porch clocks
H_SYNC, 64, hsync width
H_BP, 90, back porch (H_TOTAL = 682 >= 1032/2 needed by scaler per line pair)
V_ACTIVE, 480, visible lines
V_FP, 10, front porch lines
V_SYNC, 2, vsync lines
V_BP, 33, back porch lines
SYNC_POL, 0, sync polarity (0 = active-low)

Ports:
clk  in  1  pixel/scaler clock, one output pixel per clock
reset  in  1  synchronous, active-high
enable  in  1  0 forces SEARCH state and blank output
outpixel  in  15  from Hq2x, {b[14:10],g[9:5],r[4:0]}, valid 1 clk after read_x
frame_available  in  1  from Hq2x
read_x  out  10  line-buffer read address to Hq2x
reset_line  out  1  one-clock pulse, starts next scaler line pair
reset_frame  out  1  one-clock pulse, restarts scaler line count
r, g, b  out  5 each  video, zero when de=0
de  out  1  data enable
hsync, vsync  out  1 each  sync, polarity per SYNC_POL
locked  out  1  high in RUN state

Behaviour:
- Counters:
  - hcnt runs 0..H_TOTAL-1. vcnt increments on hcnt wrap, range 0..V_TOTAL-1.
  - Both are 0 after reset.
  - Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- read_x is registered and equals {vcnt[0], hcnt[8:0]} of the current counter.
  - Scaler read latency is 1 clock, plus 1 clock for the output register: total 2 clocks.
  - de, hsync and vsync come from the counters through a 2-stage delay, so rgb and de align exactly.
- hsync is active for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
- reset_line:
  - High for exactly one clock at hcnt == H_ACTIVE when vcnt[0] == 1, on every odd line including blanking.
  - Never asserted on two consecutive clocks.
- reset_frame:
  - High for one clock at hcnt == 0, vcnt == V_TOTAL-4.
  - This lets the scaler fill two lines before vcnt = 0.
- FSM with two states, SEARCH and RUN:
  - SEARCH: counters run; reset_line and reset_frame are generated; de=0 and rgb=0.
  - SEARCH -> RUN: frame_available == 1 sampled while vcnt >= V_TOTAL-4 or vcnt == 0. The transition takes effect at the next vcnt == 0, hcnt == 0.
  - RUN: de and rgb follow the active region.
  - RUN -> SEARCH: enable == 0, or a full frame passes (vcnt wraps) without frame_available. Blanking takes effect on the following clock.
  - locked = (state == RUN), registered.
- Reset:
  - Synchronous, wins over everything; also applies mid-line and mid-frame.
  - Counters = 0, state = SEARCH.
  - read_x = 0, reset_line = 0, reset_frame = 0.
  - r = g = b = 0, de = 0, and both delay stages are cleared.
  - hsync and vsync go to their inactive level.
- rgb:
  - r = outpixel[4:0], g = outpixel[9:5], b = outpixel[14:10], registered.
  - Forced to 0 when the delayed de is 0.
- Simultaneous events:
  - reset has top priority, then enable == 0, then the FSM transition.
  - reset_line and reset_frame never coincide, because their hcnt values differ.

Decomposition:
- Package hq2x_pkg holds:
  - the default timing constants (H_/V_ values, H_TOTAL, V_TOTAL);
  - the state enum {SEARCH, RUN};
  - the 15-bit pixel typedef with r/g/b field slices.
- One sub-module, vga_timing_gen. It holds the counters and produces raw de/hsync/vsync/hcnt/vcnt.
- The top level adds the FSM, the scaler control pulses and the 2-stage alignment pipeline.

Test Plan:
- Reset released, enable=1, frame_available tied 0 -> per line: hsync low for exactly 64 clocks starting at hcnt 528. Per frame: vsync low for 2 lines starting at vcnt 490. de and rgb stay 0, locked=0.
- Odd/even lines -> reset_line is exactly one clock wide at hcnt 512 of vcnt 1, 3, 5..., once every 1364 clocks. reset_frame is one pulse per frame at vcnt V_TOTAL-4, hcnt 0.
- Behavioural Hq2x model returning outpixel = {5'd3, read_x[9:5], read_x[4:0]} with 1-clock latency, frame_available pulsed at vcnt V_TOTAL-3 -> locked=1 from vcnt 0. At the first active pixel r=0, g=0, b=3. At hcnt-aligned x=37 on an odd line, r=5, g=17, b=3. de is high for exactly 512 clocks per line on 480 lines.
- In RUN, enable dropped for 1 clock -> de=0 on the next clock, locked=0. Relock only after the next frame_available window.
- Synchronous reset asserted mid-line at hcnt 300 -> all outputs at reset values on the following clock, counters restart at 0, and no reset_line pulse is emitted for the truncated line.
- In RUN, frame_available withheld for a whole frame -> return to SEARCH at the vcnt wrap, with rgb and de 0 from then on.

Source files
------------

// File: rtl/hq2x_pkg.sv
// Shared timing defaults, FSM states and pixel layout for the Hq2x VGA output stage.
package hq2x_pkg;

   localparam int H_ACTIVE_D = 512;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 64;
   localparam int H_BP_D     = 90;
   localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic {SEARCH = 1'b0, RUN = 1'b1} state_t;

   typedef struct packed {
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } pixel_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running raster counters plus raw (undelayed, active-high) de/hsync/vsync.
module vga_timing_gen
   import hq2x_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic clk,
   input  logic reset,
   output cnt_t hcnt,
   output cnt_t vcnt,
   output cnt_t hcnt_nxt,
   output cnt_t vcnt_nxt,
   output logic raw_de,
   output logic raw_hs,
   output logic raw_vs
);

   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
   localparam cnt_t V_ACT_C = cnt_t'(V_ACTIVE);
   localparam cnt_t HS_ON   = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t HS_OFF  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t VS_ON   = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t VS_OFF  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   // Next-count values are exported so the top can register decodes that line up with the counters.
   always_comb begin
      hcnt_nxt = hcnt + cnt_t'(1);
      vcnt_nxt = vcnt;
      if (hcnt == H_LAST) begin
         hcnt_nxt = '0;
         vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + cnt_t'(1);
      end
      if (reset) begin
         hcnt_nxt = '0;
         vcnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         hcnt <= hcnt_nxt;
         vcnt <= vcnt_nxt;
      end
   end

   assign raw_de = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
   assign raw_hs = (hcnt >= HS_ON) && (hcnt < HS_OFF);
   assign raw_vs = (vcnt >= VS_ON) && (vcnt < VS_OFF);

endmodule

// File: rtl/hq2x_vga_out.sv
// VGA output stage for Hq2x: lock FSM, scaler line/frame control and 2-clock alignment of video with timing.
module hq2x_vga_out
   import hq2x_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [14:0] outpixel,
   input  logic        frame_available,
   output logic [9:0]  read_x,
   output logic        reset_line,
   output logic        reset_frame,
   output logic [4:0]  r,
   output logic [4:0]  g,
   output logic [4:0]  b,
   output logic        de,
   output logic        hsync,
   output logic        vsync,
   output logic        locked
);

   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam cnt_t H_ACT_C = cnt_t'(H_ACTIVE);
   localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
   localparam cnt_t V_PRE   = cnt_t'(V_TOTAL - 4);

   cnt_t   hcnt, vcnt, hcnt_nxt, vcnt_nxt;
   logic   raw_de, raw_hs, raw_vs;
   state_t state, state_nxt;
   logic   armed, armed_nxt, seen, seen_nxt;
   logic   in_window, frame_end, run_nxt;
   logic   de_p1, de_p2, hs_p1, hs_p2, vs_p1, vs_p2;
   pixel_t px_p2;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk      (clk),
      .reset    (reset),
      .hcnt     (hcnt),
      .vcnt     (vcnt),
      .hcnt_nxt (hcnt_nxt),
      .vcnt_nxt (vcnt_nxt),
      .raw_de   (raw_de),
      .raw_hs   (raw_hs),
      .raw_vs   (raw_vs)
   );

   // Lock window spans the scaler's two prefill lines up to the first line of the frame.
   assign in_window = (vcnt >= V_PRE) || (vcnt == '0);
   assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
   assign run_nxt   = (state_nxt == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SEARCH;
         armed <= 1'b0;
         seen  <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= armed_nxt;
         seen  <= seen_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      armed_nxt = armed;
      seen_nxt  = seen;
      if (!enable) begin
         state_nxt = SEARCH;
         armed_nxt = 1'b0;
         seen_nxt  = 1'b0;
      end else begin
         case (state)
            SEARCH: begin
               if (frame_available && in_window) armed_nxt = 1'b1;
               if (frame_end && armed_nxt) begin
                  state_nxt = RUN;
                  armed_nxt = 1'b0;
                  seen_nxt  = 1'b0;
               end
            end
            RUN: begin
               if (frame_available) seen_nxt = 1'b1;
               if (frame_end) begin
                  if (!seen_nxt) state_nxt = SEARCH;
                  seen_nxt = 1'b0;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // Stage p1: read address issued; stage p2: scaler pixel captured alongside delayed timing.
   always_ff @(posedge clk) begin
      if (reset) begin
         locked      <= 1'b0;
         read_x      <= '0;
         reset_line  <= 1'b0;
         reset_frame <= 1'b0;
         de_p1       <= 1'b0;
         de_p2       <= 1'b0;
         hs_p1       <= 1'b0;
         hs_p2       <= 1'b0;
         vs_p1       <= 1'b0;
         vs_p2       <= 1'b0;
         px_p2       <= '0;
      end else begin
         locked      <= run_nxt;
         read_x      <= {vcnt_nxt[0], hcnt_nxt[8:0]};
         reset_line  <= (hcnt_nxt == H_ACT_C) && vcnt_nxt[0];
         reset_frame <= (hcnt_nxt == '0) && (vcnt_nxt == V_PRE);
         de_p1       <= raw_de && run_nxt;
         de_p2       <= de_p1 && run_nxt;
         hs_p1       <= raw_hs;
         hs_p2       <= hs_p1;
         vs_p1       <= raw_vs;
         vs_p2       <= vs_p1;
         px_p2       <= (de_p1 && run_nxt) ? pixel_t'(outpixel) : '0;
      end
   end

   assign de    = de_p2;
   assign r     = px_p2.r;
   assign g     = px_p2.g;
   assign b     = px_p2.b;
   assign hsync = SYNC_POL ? hs_p2 : ~hs_p2;
   assign vsync = SYNC_POL ? vs_p2 : ~vs_p2;

endmodule
